// File: rtl/wb_interconnect.sv
// Round-robin N:1 pipelined Wishbone arbiter with M-way address decode and in-order ack routing.
// Optional ack watchdog is compiled in when WB_TIMEOUT_EN is defined.
module wb_interconnect #(
  parameter int unsigned NUM_CTRL        = 3,
  parameter int unsigned NUM_PERIPH      = 3,
  parameter int unsigned ADDR_WIDTH      = 20,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter logic [NUM_PERIPH*ADDR_WIDTH-1:0] PERIPH_BASE = {20'h10100, 20'h10000, 20'h00000},
  parameter logic [NUM_PERIPH*ADDR_WIDTH-1:0] PERIPH_MASK = {20'hFFFFF, 20'hFFF00, 20'hF0000},
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                             wb_clock_i,
  input  logic                             wb_reset_ni,
  input  logic [NUM_CTRL*ADDR_WIDTH-1:0]   ctrl_addr_i,
  input  logic [NUM_CTRL*DATA_WIDTH-1:0]   ctrl_data_i,
  input  logic [NUM_CTRL-1:0]              ctrl_we_i,
  input  logic [NUM_CTRL-1:0]              ctrl_cycle_i,
  input  logic [NUM_CTRL-1:0]              ctrl_strobe_i,
  output logic [NUM_CTRL-1:0]              ctrl_stall_o,
  output logic [NUM_CTRL-1:0]              ctrl_ack_o,
  output logic [DATA_WIDTH-1:0]            ctrl_data_o,
  output logic [ADDR_WIDTH-1:0]            periph_addr_o,
  output logic [DATA_WIDTH-1:0]            periph_data_o,
  output logic                             periph_we_o,
  output logic [NUM_PERIPH-1:0]            periph_cycle_o,
  output logic [NUM_PERIPH-1:0]            periph_strobe_o,
  input  logic [NUM_PERIPH-1:0]            periph_stall_i,
  input  logic [NUM_PERIPH-1:0]            periph_ack_i,
  input  logic [NUM_PERIPH*DATA_WIDTH-1:0] periph_data_i,
  output logic [NUM_CTRL-1:0]              grant_o,
  output logic                             timeout_o
);

  localparam int unsigned CW = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
  localparam int unsigned PW = $clog2(NUM_PERIPH + 1);
  localparam int unsigned FW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned NW = FW + 1;
  localparam logic [PW-1:0] UNMAPPED = PW'(NUM_PERIPH);

  typedef enum logic {IDLE, GRANTED} state_e;

  state_e                state_q, state_d;
  logic [NUM_CTRL-1:0]   grant_q, grant_d;
  logic [CW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]         fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]         fifo_d [MAX_OUTSTANDING];
  logic [FW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]         count_q, count_d;
  logic                  unm_wait_q, unm_wait_d;

  logic [CW-1:0]         win_idx_c;
  logic                  g_cyc_c, g_stb_c;
  logic [PW-1:0]         sel_c, head_c;
  logic                  sel_stall_c, head_ack_c;
  logic [DATA_WIDTH-1:0] head_data_c;
  logic                  fifo_full_c, fifo_empty_c;
  logic                  push_c, pop_c, ack_c, stall_c;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_o      = 1'b0;
`endif

  // Round-robin: requesters above rr_ptr beat those at or below it; lowest index wins in each group.
  always_comb begin
    win_idx_c = '0;
    for (int c = NUM_CTRL - 1; c >= 0; c--)
      if (ctrl_cycle_i[c] && c <= int'(rr_ptr_q)) win_idx_c = CW'(c);
    for (int c = NUM_CTRL - 1; c >= 0; c--)
      if (ctrl_cycle_i[c] && c > int'(rr_ptr_q)) win_idx_c = CW'(c);
  end

  // rr_ptr holds the current owner while GRANTED.
  always_comb begin
    periph_addr_o = '0;
    periph_data_o = '0;
    periph_we_o   = 1'b0;
    g_cyc_c       = 1'b0;
    g_stb_c       = 1'b0;
    for (int c = 0; c < NUM_CTRL; c++) begin
      if (rr_ptr_q == CW'(c)) begin
        periph_addr_o = ctrl_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
        periph_data_o = ctrl_data_i[c*DATA_WIDTH +: DATA_WIDTH];
        periph_we_o   = ctrl_we_i[c];
        g_cyc_c       = ctrl_cycle_i[c];
        g_stb_c       = ctrl_strobe_i[c];
      end
    end
  end

  always_comb begin
    sel_c       = UNMAPPED;
    sel_stall_c = 1'b0;
    for (int p = NUM_PERIPH - 1; p >= 0; p--)
      if ((periph_addr_o & PERIPH_MASK[p*ADDR_WIDTH +: ADDR_WIDTH]) ==
          PERIPH_BASE[p*ADDR_WIDTH +: ADDR_WIDTH]) sel_c = PW'(p);
    for (int p = 0; p < NUM_PERIPH; p++)
      if (sel_c == PW'(p)) sel_stall_c = periph_stall_i[p];
  end

  always_comb begin
    head_c      = fifo_q[rd_ptr_q];
    head_ack_c  = 1'b0;
    head_data_c = '0;
    for (int p = 0; p < NUM_PERIPH; p++) begin
      if (head_c == PW'(p)) begin
        head_ack_c  = periph_ack_i[p];
        head_data_c = periph_data_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign fifo_full_c  = (count_q == NW'(MAX_OUTSTANDING));
  assign fifo_empty_c = (count_q == '0);

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_ptr_d        = rr_ptr_q;
    fifo_d          = fifo_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    unm_wait_d      = 1'b0;
    push_c          = 1'b0;
    pop_c           = 1'b0;
    ack_c           = 1'b0;
    stall_c         = 1'b1;
    ctrl_data_o     = '0;
    periph_cycle_o  = '0;
    periph_strobe_o = '0;
`ifdef WB_TIMEOUT_EN
    timeout_o       = 1'b0;
    to_cnt_d        = '0;
`endif
    case (state_q)
      IDLE: begin
        if (|ctrl_cycle_i) begin
          state_d  = GRANTED;
          grant_d  = NUM_CTRL'(1) << win_idx_c;
          rr_ptr_d = win_idx_c;
        end
      end
      GRANTED: begin
        if (!g_cyc_c) begin
          // Release: outstanding entries are abandoned, late acks fall on the floor.
          state_d  = IDLE;
          grant_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          periph_cycle_o = '1;
          for (int p = 0; p < NUM_PERIPH; p++)
            if (sel_c == PW'(p)) periph_strobe_o[p] = g_stb_c & ~fifo_full_c;
          stall_c = fifo_full_c | sel_stall_c;
          push_c  = g_stb_c & ~stall_c;
          if (!fifo_empty_c) begin
            if (head_c == UNMAPPED) begin
              if (unm_wait_q) begin
                pop_c       = 1'b1;
                ack_c       = 1'b1;
                ctrl_data_o = '1;
              end else begin
                unm_wait_d = 1'b1;
              end
            end else if (head_ack_c) begin
              pop_c       = 1'b1;
              ack_c       = 1'b1;
              ctrl_data_o = head_data_c;
            end
`ifdef WB_TIMEOUT_EN
            // Fires on the TIMEOUT_CYCLES-th cycle the head has gone unanswered.
            if (!pop_c) begin
              if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                pop_c       = 1'b1;
                ack_c       = 1'b1;
                ctrl_data_o = '1;
                timeout_o   = 1'b1;
                unm_wait_d  = 1'b0;
              end else begin
                to_cnt_d = to_cnt_q + 1'b1;
              end
            end
`endif
          end
          if (push_c) begin
            fifo_d[wr_ptr_q] = sel_c;
            wr_ptr_d         = wr_ptr_q + 1'b1;
          end
          if (pop_c) rd_ptr_d = rd_ptr_q + 1'b1;
          if (push_c && !pop_c)      count_d = count_q + 1'b1;
          else if (pop_c && !push_c) count_d = count_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ctrl_stall_o = ~grant_q | {NUM_CTRL{stall_c}};
  assign ctrl_ack_o   = grant_q & {NUM_CTRL{ack_c}};
  assign grant_o      = grant_q;

  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= CW'(NUM_CTRL - 1);
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      unm_wait_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      unm_wait_q <= unm_wait_d;
    end
  end

`ifdef WB_TIMEOUT_EN
  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) to_cnt_q <= '0;
    else              to_cnt_q <= to_cnt_d;
  end
`endif

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect: vector table for decode/routing, hand sequences for
// arbitration, FIFO-full stall, out-of-order acks, watchdog and asynchronous reset.
module tb_wb_interconnect;
  localparam int unsigned NC = 3;
  localparam int unsigned NP = 3;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NC*AW-1:0] ctrl_addr;
  logic [NC*DW-1:0] ctrl_wdata;
  logic [NC-1:0]    ctrl_we, ctrl_cyc, ctrl_stb, ctrl_stall, ctrl_ack, grant;
  logic [DW-1:0]    ctrl_rdata, p_wdata;
  logic [AW-1:0]    p_addr;
  logic             p_we, timeout;
  logic [NP-1:0]    p_cyc, p_stb, p_stall, p_ack;
  logic [NP*DW-1:0] p_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          stb;
    logic [NP-1:0] pstall;
    logic [NP-1:0] pack;
    logic [NP-1:0] e_stb;
    logic          e_stall;
    logic          e_ack;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  assign p_rdata = {8'hC2, 8'hB1, 8'hA0};

  wb_interconnect #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clock_i     (clk),
    .wb_reset_ni    (rst_n),
    .ctrl_addr_i    (ctrl_addr),
    .ctrl_data_i    (ctrl_wdata),
    .ctrl_we_i      (ctrl_we),
    .ctrl_cycle_i   (ctrl_cyc),
    .ctrl_strobe_i  (ctrl_stb),
    .ctrl_stall_o   (ctrl_stall),
    .ctrl_ack_o     (ctrl_ack),
    .ctrl_data_o    (ctrl_rdata),
    .periph_addr_o  (p_addr),
    .periph_data_o  (p_wdata),
    .periph_we_o    (p_we),
    .periph_cycle_o (p_cyc),
    .periph_strobe_o(p_stb),
    .periph_stall_i (p_stall),
    .periph_ack_i   (p_ack),
    .periph_data_i  (p_rdata),
    .grant_o        (grant),
    .timeout_o      (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic [AW-1:0] a, input logic s, input logic [NP-1:0] ack);
    ctrl_addr[AW-1:0] = a;
    ctrl_stb[0]       = s;
    p_ack             = ack;
  endtask

  task automatic open0();
    ctrl_cyc = 3'b001;
    cycle();
  endtask

  task automatic close_all();
    ctrl_cyc = '0;
    ctrl_stb = '0;
    p_ack    = '0;
    p_stall  = '0;
    cycle();
    cycle();
  endtask

  int acks_seen, tos_seen;

  initial begin
    rst_n      = 1'b0;
    ctrl_addr  = '0;
    ctrl_wdata = {8'h33, 8'h22, 8'h11};
    ctrl_we    = 3'b010;
    ctrl_cyc   = '0;
    ctrl_stb   = '0;
    p_stall    = '0;
    p_ack      = '0;

    //                 addr        stb   pstall  pack    e_stb   stall ack   data
    tbl[0]  = '{20'h00010, 1'b1, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{20'h10005, 1'b1, 3'b010, 3'b000, 3'b010, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{20'h10005, 1'b1, 3'b000, 3'b001, 3'b010, 1'b0, 1'b1, 8'hA0};
    tbl[3]  = '{20'h10100, 1'b1, 3'b000, 3'b010, 3'b100, 1'b0, 1'b1, 8'hB1};
    tbl[4]  = '{20'hFFFFF, 1'b1, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{20'h00000, 1'b0, 3'b000, 3'b100, 3'b000, 1'b0, 1'b1, 8'hC2};
    tbl[6]  = '{20'h00000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{20'h00000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 8'hFF};
    tbl[8]  = '{20'h00000, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{20'h20000, 1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{20'h00000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{20'h00000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 8'hFF};

    // Reset state
    #12;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_stall", 32'(ctrl_stall), 32'h7);
    chk("rst_ack", 32'(ctrl_ack), 0);
    chk("rst_pcyc", 32'(p_cyc), 0);
    chk("rst_pstb", 32'(p_stb), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_rdata", 32'(ctrl_rdata), 0);

    // Arbitration: simultaneous request, release gap, rotation
    rst_n    = 1'b1;
    ctrl_cyc = 3'b011;
    #1;
    chk("arb_latency", 32'(grant), 0);
    cycle();
    chk("arb_first", 32'(grant), 32'h1);
    ctrl_cyc = 3'b010;
    @(negedge clk);
    chk("arb_rel_pcyc", 32'(p_cyc), 0);
    cycle();
    chk("arb_gap", 32'(grant), 0);
    chk("arb_gap_stall", 32'(ctrl_stall), 32'h7);
    cycle();
    chk("arb_second", 32'(grant), 32'h2);
    @(negedge clk);
    chk("arb_g1_stall", 32'(ctrl_stall), 32'h5);
    chk("arb_g1_pcyc", 32'(p_cyc), 32'h7);
    chk("arb_g1_wdata", 32'(p_wdata), 32'h22);
    chk("arb_g1_we", 32'(p_we), 1);
    ctrl_cyc = 3'b101;
    cycle();
    chk("arb_gap2", 32'(grant), 0);
    cycle();
    chk("arb_rotate", 32'(grant), 32'h4);
    close_all();
    ctrl_we = '0;

    // Vector table: decode, strobe, stall and in-order ack routing
    open0();
    for (int i = 0; i < 12; i++) begin
      drv0(tbl[i].addr, tbl[i].stb, tbl[i].pack);
      p_stall = tbl[i].pstall;
      @(negedge clk);
      chk($sformatf("vec%0d_paddr", i), 32'(p_addr), 32'(tbl[i].addr));
      chk($sformatf("vec%0d_pstb", i), 32'(p_stb), 32'(tbl[i].e_stb));
      chk($sformatf("vec%0d_stall", i), 32'(ctrl_stall), 32'({2'b11, tbl[i].e_stall}));
      chk($sformatf("vec%0d_ack", i), 32'(ctrl_ack), 32'({2'b00, tbl[i].e_ack}));
      chk($sformatf("vec%0d_data", i), 32'(ctrl_rdata), 32'(tbl[i].e_data));
      cycle();
    end
    close_all();

    // FIFO full: 4 RAM reads outstanding, 5th strobe stalls until the first ack
    open0();
    for (int k = 0; k < 4; k++) begin
      drv0(20'h00100 + 20'(k), 1'b1, 3'b000);
      @(negedge clk);
      chk($sformatf("full_acc%0d_stall", k), 32'(ctrl_stall), 32'h6);
      chk($sformatf("full_acc%0d_pstb", k), 32'(p_stb), 32'h1);
      cycle();
    end
    drv0(20'h10002, 1'b1, 3'b000);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("full_stall%0d", k), 32'(ctrl_stall), 32'h7);
      chk($sformatf("full_pstb%0d", k), 32'(p_stb), 0);
      chk($sformatf("full_noack%0d", k), 32'(ctrl_ack), 0);
      cycle();
    end
    p_ack = 3'b001;
    @(negedge clk);
    chk("full_ack1", 32'(ctrl_ack), 32'h1);
    chk("full_ack1_data", 32'(ctrl_rdata), 32'hA0);
    chk("full_ack1_stall", 32'(ctrl_stall), 32'h7);
    cycle();
    @(negedge clk);
    chk("full_ack2", 32'(ctrl_ack), 32'h1);
    chk("full_ack2_data", 32'(ctrl_rdata), 32'hA0);
    chk("full_5th_accept", 32'(p_stb), 32'h2);
    chk("full_5th_stall", 32'(ctrl_stall), 32'h6);
    cycle();
    ctrl_stb[0] = 1'b0;
    for (int k = 3; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("full_ack%0d", k), 32'(ctrl_ack), 32'h1);
      chk($sformatf("full_ack%0d_data", k), 32'(ctrl_rdata), 32'hA0);
      cycle();
    end
    p_ack = 3'b010;
    @(negedge clk);
    chk("full_ack5", 32'(ctrl_ack), 32'h1);
    chk("full_ack5_data", 32'(ctrl_rdata), 32'hB1);
    cycle();
    p_ack = 3'b000;
    @(negedge clk);
    chk("full_drained", 32'(ctrl_ack), 0);
    close_all();

    // Ack from a non-head peripheral is ignored
    open0();
    drv0(20'h00000, 1'b1, 3'b000);
    cycle();
    drv0(20'h00000, 1'b0, 3'b010);
    @(negedge clk);
    chk("ooo_ignored", 32'(ctrl_ack), 0);
    cycle();
    p_ack = 3'b001;
    @(negedge clk);
    chk("ooo_head_ack", 32'(ctrl_ack), 32'h1);
    chk("ooo_head_data", 32'(ctrl_rdata), 32'hA0);
    close_all();

    // Watchdog: RAM never answers
    open0();
    drv0(20'h00000, 1'b1, 3'b000);
    cycle();
    ctrl_stb[0] = 1'b0;
`ifdef WB_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("wd_ack_c%0d", k), 32'(ctrl_ack), (k == 8) ? 32'h1 : 32'h0);
      chk($sformatf("wd_pulse_c%0d", k), 32'(timeout), (k == 8) ? 32'h1 : 32'h0);
      if (k == 8) chk("wd_data", 32'(ctrl_rdata), 32'hFF);
      cycle();
    end
`else
    acks_seen = 0;
    tos_seen  = 0;
    repeat (1000) begin
      @(negedge clk);
      if (ctrl_ack != '0) acks_seen++;
      if (timeout) tos_seen++;
    end
    chk("wd_off_no_ack", 32'(acks_seen), 0);
    chk("wd_off_no_pulse", 32'(tos_seen), 0);
`endif
    close_all();

    // Asynchronous reset with two reads outstanding
    open0();
    drv0(20'h00000, 1'b1, 3'b000);
    cycle();
    cycle();
    drv0(20'h00000, 1'b0, 3'b001);
    ctrl_cyc = 3'b011;
    @(negedge clk);
    chk("ar_pre_ack", 32'(ctrl_ack), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_grant", 32'(grant), 0);
    chk("ar_ack", 32'(ctrl_ack), 0);
    chk("ar_pcyc", 32'(p_cyc), 0);
    chk("ar_stall", 32'(ctrl_stall), 32'h7);
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("ar_ctrl0_wins", 32'(grant), 32'h1);
    @(negedge clk);
    chk("ar_fifo_flushed", 32'(ctrl_ack), 0);
    close_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_interconnect.md
Name: wb_interconnect

Overview:
Parametrised successor to the fixed SPI/video arbiter and OR-ed ack/stall fabric in the top level. N Wishbone (pipelined, classic-B4) controllers are arbitrated round-robin onto one shared bus, which is address-decoded to M peripherals. Acks and read data are routed back in order through an outstanding-request FIFO. Unmapped addresses get a default response, so the MCU's SPI bridge never hangs.

Parameters:
NUM_CTRL, 3, number of controllers (SPI1, video, spare); 1..8
NUM_PERIPH, 3, number of peripherals (ram, register_file, keyboard); 1..8
ADDR_WIDTH, 20, Wishbone address width
DATA_WIDTH, 8, Wishbone data width
PERIPH_BASE, packed NUM_PERIPH*ADDR_WIDTH, base address of each peripheral
PERIPH_MASK, packed NUM_PERIPH*ADDR_WIDTH, decode mask; peripheral p is selected when (addr & MASK[p]) == BASE[p]
MAX_OUTSTANDING, 4, depth of the ack-routing FIFO; power of 2, at least 2
TIMEOUT_CYCLES, 255, watchdog limit; used only with WB_TIMEOUT_EN

Ports:
wb_clock_i  in  1  system clock (64 MHz)
wb_reset_ni  in  1  asynchronous, active-low reset
ctrl_addr_i  in  NUM_CTRL*ADDR_WIDTH  controller addresses
ctrl_data_i  in  NUM_CTRL*DATA_WIDTH  controller write data
ctrl_we_i  in  NUM_CTRL  controller write enables
ctrl_cycle_i  in  NUM_CTRL  controller CYC
ctrl_strobe_i  in  NUM_CTRL  controller STB
ctrl_stall_o  out  NUM_CTRL  per-controller stall
ctrl_ack_o  out  NUM_CTRL  per-controller ack
ctrl_data_o  out  DATA_WIDTH  shared read data; valid only with ack
periph_addr_o  out  ADDR_WIDTH  address of the granted controller
periph_data_o  out  DATA_WIDTH  write data of the granted controller
periph_we_o  out  1  WE of the granted controller
periph_cycle_o  out  NUM_PERIPH  CYC to every peripheral while a grant is held
periph_strobe_o  out  NUM_PERIPH  decoded STB
periph_stall_i  in  NUM_PERIPH  peripheral stalls
periph_ack_i  in  NUM_PERIPH  peripheral acks
periph_data_i  in  NUM_PERIPH*DATA_WIDTH  peripheral read data
grant_o  out  NUM_CTRL  one-hot current grant (registered)
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (async, wb_reset_ni=0): grant_o=0, FIFO empty, rr_ptr=NUM_CTRL-1 (so ctrl0 wins first), ctrl_ack_o=0, ctrl_stall_o=all 1, periph_cycle_o=0, periph_strobe_o=0, timeout_o=0, ctrl_data_o=0.
- States: IDLE, GRANTED.
- IDLE:
  - ctrl_stall_o = all 1.
  - If any ctrl_cycle_i is high, pick the first requester scanning rr_ptr+1 .. rr_ptr+NUM_CTRL (mod NUM_CTRL).
  - Register grant_o, set rr_ptr to the winner, go to GRANTED. Grant takes effect the next cycle: 1-cycle arbitration latency.
- GRANTED (controller g):
  - periph_addr_o, periph_data_o, periph_we_o are muxed combinationally from g.
  - periph_cycle_o = all 1 while ctrl_cycle_i[g] is high.
  - Decode: sel = lowest-index matching peripheral. No match = UNMAPPED.
  - periph_strobe_o[sel] = ctrl_strobe_i[g] & !fifo_full.
  - ctrl_stall_o[g] = fifo_full | (mapped ? periph_stall_i[sel] : 0). ctrl_stall_o for all other controllers = 1.
  - Accept (strobe & !stall): push sel, or UNMAPPED code NUM_PERIPH, into the FIFO.
  - Ack routing:
    - If the FIFO head is peripheral h and periph_ack_i[h]=1: ctrl_ack_o[g]=1, ctrl_data_o=periph_data_i[h], pop.
    - If the head is UNMAPPED: ack with data all-ones one cycle after it reaches the head, then pop.
    - Acks from non-head peripherals and acks while the FIFO is empty are ignored.
  - Ack output is combinational from periph_ack_i: 0 added latency.
  - Push and pop in the same cycle leave the count unchanged. Full (count==MAX_OUTSTANDING) stalls the controller. Pop on empty cannot occur.
  - Release: when ctrl_cycle_i[g] falls, periph_cycle_o and strobe drop the same cycle (combinational), the FIFO is flushed, and late acks are dropped. Next edge: grant_o=0, IDLE. The minimum gap between grants is 1 idle cycle. The releasing controller has lowest priority at the next arbitration.
- A grant is never pre-empted. A controller holding CYC indefinitely starves the others; that is by design, because video bursts are bounded.
- Reset asserted mid-transaction: all state is cleared immediately. Outstanding transactions are abandoned with no ack.

Optional Feature:
WB_TIMEOUT_EN
- Defined:
  - A counter increments while the FIFO is non-empty and no ack occurs. It clears on any pop or when the FIFO is empty.
  - When it reaches TIMEOUT_CYCLES: synthesize ctrl_ack_o[g] with data all-ones, pop the head, pulse timeout_o for 1 cycle, clear the counter.
- Undefined: no counter logic; timeout_o is tied to 0; the interconnect waits for an ack indefinitely.

Test Plan:
- ctrl0 and ctrl1 both raise CYC in the same cycle after reset -> grant_o=3'b001 the next cycle. When ctrl0 drops CYC, grant_o=0 for 1 cycle, then 3'b010.
- ctrl0 issues 4 back-to-back reads to RAM (p0, 2-cycle ack latency), then 1 read to register_file (p1), with MAX_OUTSTANDING=4 -> ctrl_stall_o[0]=1 on the 5th strobe until the first ack. The 5 acks return in order with p0, p0, p0, p0, p1 data.
- p1 acks before the pending p0 head -> the p1 ack is ignored and no ctrl_ack_o is produced; a later p0 ack is delivered with p0 data.
- Read from an unmapped address 0xFFFFF -> ctrl_ack_o[g]=1 with ctrl_data_o=8'hFF, 1 cycle after the request reaches the FIFO head.
- WB_TIMEOUT_EN with TIMEOUT_CYCLES=8, peripheral never acks -> ack with data 8'hFF and a timeout_o pulse exactly 8 cycles after the accept. Without the macro: no ack after 1000 cycles, timeout_o=0.
- wb_reset_ni pulsed low with 2 transactions outstanding -> grant_o, ctrl_ack_o, periph_cycle_o go to 0 asynchronously. After release, ctrl0 wins the next arbitration.
